apb_req_arbiter: RTL and testbench

//  Shares one APB master port between NUM_REQ requesters, e.g. the AXI read and write command paths or a debug port.
//  - Round-robin arbitration; one APB transfer in flight at a time.
//  - Drives the APB SETUP/ACCESS sequence and returns read data and error status to the granted requester.
//  - Sits between the command sources and the per-slave APB decode mux.

---
 rtl/apb_arb_pkg.sv | 24 ++
 rtl/apb_rr_arbiter.sv | 29 ++
 rtl/apb_req_arbiter.sv | 113 +++++++++++
 tb/tb_apb_req_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared FSM state type, APB data width and the round-robin pick helper
//   state_e        IDLE/SETUP/ACCESS/RESP transfer phases
//   APB_DATA_WIDTH fixed APB data width
//   rr_pick        first set request bit after ptr, wrapping within n requesters
package apb_arb_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;
    localparam int APB_DATA_WIDTH = 32;
    localparam int MAX_REQ = 8;
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req, input logic [2:0] ptr, input int unsigned n);
        logic [2:0] g;
        logic hit;
        int unsigned idx;
        g = ptr;
        hit = 1'b0;
        for (int unsigned i = 1; i <= MAX_REQ; i++) begin
            idx = (32'(ptr) + i) % n;
            if (!hit && i <= n && req[idx[2:0]]) begin
                g = idx[2:0];
                hit = 1'b1;
            end
        end
        return g;
    endfunction
endpackage

// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: combinational round-robin pick plus the last-grant pointer
//   clk, rstn   clock, async active-low reset
//   i_req       request vector
//   i_advance   grant taken this cycle; pointer moves to the winner
//   o_gnt       winning index, searching upward from the pointer + 1
//   o_any       at least one request pending
module apb_rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic                       i_advance,
    output logic [$clog2(NUM_REQ)-1:0] o_gnt,
    output logic                       o_any
);
    logic [2:0] r_ptr;
    logic [2:0] w_pick;
    assign w_pick = rr_pick(8'(i_req), r_ptr, NUM_REQ);
    assign o_gnt  = w_pick[$clog2(NUM_REQ)-1:0];
    assign o_any  = |i_req;
    // pointer starts at the last requester so requester 0 wins first after reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_ptr <= 3'(NUM_REQ - 1);
        else if (i_advance) r_ptr <= w_pick;
    end
endmodule

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin sharing of one APB master port among NUM_REQ requesters
//   clk, rstn                                  clock, async active-low reset
//   req_valid/req_ready/req_write/addr/wdata   command side; req_ready is a 1-cycle accept
//   rsp_valid/rsp_rdata/rsp_err                1-cycle completion to the granted requester
//   psel/penable/pwrite/paddr/pwdata           APB request outputs
//   prdata/pready/pslverr                      APB completion inputs
//   APB_TIMEOUT_EN                             enables the ACCESS-phase timeout abort
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ-1:0]                 req_write,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    output logic [DATA_WIDTH-1:0]              rsp_rdata,
    output logic                               rsp_err,
    output logic                               psel,
    output logic                               penable,
    output logic                               pwrite,
    output logic [ADDR_WIDTH-1:0]              paddr,
    output logic [DATA_WIDTH-1:0]              pwdata,
    input  logic [DATA_WIDTH-1:0]              prdata,
    input  logic                               pready,
    input  logic                               pslverr
);
    localparam int gw = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] one = NUM_REQ'(1);
    state_e r_state;
    logic [gw-1:0] w_gnt;
    logic [gw-1:0] r_gnt;
    logic w_any;
    logic w_accept;
    logic w_timeout;
    logic r_write;
    logic r_err;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    apb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk      (clk),
        .rstn     (rstn),
        .i_req    (req_valid),
        .i_advance(w_accept),
        .o_gnt    (w_gnt),
        .o_any    (w_any)
    );
    // rstn gates the accept so req_ready stays low while reset is held
    assign w_accept  = rstn && r_state == IDLE && w_any;
    assign req_ready = w_accept ? one << w_gnt : '0;
    assign rsp_valid = r_state == RESP ? one << r_gnt : '0;
    assign rsp_rdata = r_state == RESP ? r_rdata : '0;
    assign rsp_err   = r_state == RESP && r_err;
    assign psel      = r_state == SETUP || r_state == ACCESS;
    assign penable   = r_state == ACCESS;
    assign pwrite    = r_write;
    assign paddr     = r_addr;
    assign pwdata    = r_wdata;
`ifdef APB_TIMEOUT_EN
    localparam int tw = $clog2(TIMEOUT_CYCLES) > 8 ? $clog2(TIMEOUT_CYCLES) : 8;
    logic [tw-1:0] r_cnt;
    // counts ACCESS cycles without pready; cleared while in SETUP so it is 0 on ACCESS entry
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_cnt <= '0;
        else if (r_state == SETUP) r_cnt <= '0;
        else if (r_state == ACCESS && !pready) r_cnt <= r_cnt + 1'b1;
    end
    assign w_timeout = r_state == ACCESS && !pready && r_cnt == tw'(TIMEOUT_CYCLES - 1);
`else
    // the limit has no effect without the timeout counter
    assign w_timeout = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_state <= SETUP;
                    r_gnt   <= w_gnt;
                    r_write <= req_write[w_gnt];
                    r_addr  <= req_addr[w_gnt];
                    r_wdata <= req_wdata[w_gnt];
                end
                SETUP: r_state <= ACCESS;
                ACCESS: if (pready) begin
                    r_state <= RESP;
                    r_rdata <= r_write ? '0 : prdata;
                    r_err   <= pslverr;
                end else if (w_timeout) begin
                    r_state <= RESP;
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: directed scenarios plus a randomized run against a transfer-level model
module tb_apb_req_arbiter;
    localparam int NR = 3;
    localparam int AW = 12;
    localparam int TO = 8;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [NR-1:0] req_valid, req_ready, req_write, rsp_valid;
    logic [NR-1:0][AW-1:0] req_addr;
    logic [NR-1:0][31:0] req_wdata;
    logic [31:0] rsp_rdata, pwdata, prdata;
    logic rsp_err, psel, penable, pwrite, pready, pslverr;
    logic [AW-1:0] paddr;
    int tests = 0, fails = 0;
    int obs_g, obs_n;
    logic [1:0] obs_setup;
    logic [AW-1:0] obs_addr;
    logic obs_write, obs_stable, obs_busy_ready, obs_err, obs_rsp_psel;
    logic [31:0] obs_wdata, obs_rdata;
    logic [NR-1:0] obs_rsp;

    apb_req_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        pready = 1'b0; prdata = '0; pslverr = 1'b0;
        repeat (2) tick();
        rstn = 1'b1;
    endtask

    function automatic int rr_next(input int last, input logic [NR-1:0] v);
        for (int i = 1; i <= NR; i++) if (v[(last + i) % NR]) return (last + i) % NR;
        return -1;
    endfunction

    // Runs one transfer from the IDLE accept cycle through RESP, acting as the APB slave.
    task automatic run_xfer(input int waits, input logic [31:0] rd, input logic err, input bit drop, input logic [NR-1:0] late);
        obs_g = -1; obs_n = 0; obs_stable = 1'b1; obs_busy_ready = 1'b0;
        #1;
        for (int i = 0; i < NR; i++) if (req_ready[i]) obs_g = i;
        tick();
        if (drop && obs_g >= 0) req_valid[obs_g] = 1'b0;
        obs_setup = {psel, penable}; obs_addr = paddr; obs_write = pwrite; obs_wdata = pwdata;
        #1 obs_busy_ready = obs_busy_ready | (|req_ready);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!(psel && penable)) break;
            obs_n++;
            if (obs_n == 1) req_valid = req_valid | late;
            if (paddr !== obs_addr || pwrite !== obs_write || pwdata !== obs_wdata) obs_stable = 1'b0;
            pready = obs_n > waits; prdata = rd; pslverr = err;
            #1 obs_busy_ready = obs_busy_ready | (|req_ready);
        end
        pready = 1'b0; pslverr = 1'b0;
        obs_rsp = rsp_valid; obs_rdata = rsp_rdata; obs_err = rsp_err; obs_rsp_psel = psel | penable;
        #1 obs_busy_ready = obs_busy_ready | (|req_ready);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        req_valid = '1; req_write = '1; req_addr = '1; req_wdata = '1;
        pready = 1'b1; prdata = 32'hFFFF_FFFF; pslverr = 1'b1;
        tick(); tick();
        tests++; if (req_ready !== '0) begin fails++; $display("FAIL reset_ready: got %0h want 0", req_ready); end
        tests++; if ({psel, penable} !== 2'b00) begin fails++; $display("FAIL reset_psel: got %0b want 00", {psel, penable}); end
        tests++; if (rsp_valid !== '0) begin fails++; $display("FAIL reset_rsp_valid: got %0h want 0", rsp_valid); end
        tests++; if (rsp_rdata !== '0 || rsp_err !== 1'b0) begin fails++; $display("FAIL reset_rsp: got %0h/%0b want 0/0", rsp_rdata, rsp_err); end
        tests++; if (paddr !== '0 || pwdata !== '0 || pwrite !== 1'b0) begin fails++; $display("FAIL reset_apb: got %0h/%0h/%0b want 0", paddr, pwdata, pwrite); end
        rstn = 1'b1;
        #1;
        tests++; if (req_ready !== 3'b001) begin fails++; $display("FAIL reset_first_grant: got %0b want 001", req_ready); end
    endtask

    task automatic test_single_read();
        do_reset();
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 12'h010; req_wdata[0] = 32'h1111_2222;
        run_xfer(0, 32'hCAFE_0001, 1'b0, 1'b1, '0);
        tests++; if (obs_g !== 0) begin fails++; $display("FAIL single_grant: got %0d want 0", obs_g); end
        tests++; if (obs_setup !== 2'b10) begin fails++; $display("FAIL single_setup: got %0b want 10", obs_setup); end
        tests++; if (obs_addr !== 12'h010 || obs_write !== 1'b0) begin fails++; $display("FAIL single_addr: got %0h/%0b want 010/0", obs_addr, obs_write); end
        tests++; if (obs_n !== 1) begin fails++; $display("FAIL single_access_cycles: got %0d want 1", obs_n); end
        tests++; if (obs_rsp !== 3'b001) begin fails++; $display("FAIL single_rsp_valid: got %0b want 001", obs_rsp); end
        tests++; if (obs_rdata !== 32'hCAFE_0001 || obs_err !== 1'b0) begin fails++; $display("FAIL single_rsp: got %0h/%0b want cafe0001/0", obs_rdata, obs_err); end
        tests++; if (obs_rsp_psel !== 1'b0) begin fails++; $display("FAIL single_resp_psel: got %0b want 0", obs_rsp_psel); end
        tick();
        tests++; if (rsp_valid !== '0 || psel !== 1'b0 || req_ready !== '0) begin fails++; $display("FAIL single_idle: got %0b/%0b/%0b want 0/0/0", rsp_valid, psel, req_ready); end
    endtask

    task automatic test_fairness();
        logic [31:0] rd;
        int exp;
        do_reset();
        req_write = 3'b101; req_valid = 3'b011;
        req_addr[0] = 12'h100; req_wdata[0] = 32'hA5A5_0000;
        req_addr[1] = 12'h204; req_wdata[1] = 32'h0000_5A5A;
        req_addr[2] = 12'h3FC; req_wdata[2] = 32'h3333_CCCC;
        for (int t = 0; t < 9; t++) begin
            if (t > 0) tick();
            if (t == 6) req_valid = '1;
            rd = $urandom | 32'h1;
            exp = t < 6 ? t % 2 : (t - 6 + 2) % 3;
            run_xfer(t % 2, rd, 1'b0, 1'b0, '0);
            tests++; if (obs_g !== exp) begin fails++; $display("FAIL fair_grant[%0d]: got %0d want %0d", t, obs_g, exp); end
            tests++; if (obs_rsp !== NR'(1) << exp) begin fails++; $display("FAIL fair_rsp_valid[%0d]: got %0b want %0b", t, obs_rsp, NR'(1) << exp); end
            tests++; if (obs_addr !== req_addr[exp] || obs_write !== req_write[exp] || obs_wdata !== req_wdata[exp]) begin fails++; $display("FAIL fair_payload[%0d]: got %0h/%0b/%0h want %0h/%0b/%0h", t, obs_addr, obs_write, obs_wdata, req_addr[exp], req_write[exp], req_wdata[exp]); end
            tests++; if (obs_rdata !== (req_write[exp] ? 32'h0 : rd)) begin fails++; $display("FAIL fair_rdata[%0d]: got %0h want %0h", t, obs_rdata, req_write[exp] ? 32'h0 : rd); end
        end
    endtask

    task automatic test_wait_err();
        do_reset();
        req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 12'h5A4; req_wdata[1] = 32'h1234_5678;
        run_xfer(5, 32'hDEAD_BEEF, 1'b1, 1'b1, '0);
        tests++; if (obs_g !== 1) begin fails++; $display("FAIL wait_grant: got %0d want 1", obs_g); end
        tests++; if (obs_n !== 6) begin fails++; $display("FAIL wait_access_cycles: got %0d want 6", obs_n); end
        tests++; if (obs_stable !== 1'b1) begin fails++; $display("FAIL wait_stable: got %0b want 1", obs_stable); end
        tests++; if (obs_addr !== 12'h5A4 || obs_write !== 1'b1 || obs_wdata !== 32'h1234_5678) begin fails++; $display("FAIL wait_payload: got %0h/%0b/%0h want 5a4/1/12345678", obs_addr, obs_write, obs_wdata); end
        tests++; if (obs_rsp !== 3'b010 || obs_err !== 1'b1 || obs_rdata !== 32'h0) begin fails++; $display("FAIL wait_rsp: got %0b/%0b/%0h want 010/1/0", obs_rsp, obs_err, obs_rdata); end
    endtask

    task automatic test_late_request();
        do_reset();
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 12'h020;
        req_write[1] = 1'b0; req_addr[1] = 12'h024;
        run_xfer(2, 32'h0000_00AA, 1'b0, 1'b1, 3'b010);
        tests++; if (obs_busy_ready !== 1'b0) begin fails++; $display("FAIL late_ready_busy: got %0b want 0", obs_busy_ready); end
        tests++; if (obs_rsp !== 3'b001 || obs_rdata !== 32'hAA) begin fails++; $display("FAIL late_rsp: got %0b/%0h want 001/aa", obs_rsp, obs_rdata); end
        tick();
        tests++; if (req_ready !== 3'b010) begin fails++; $display("FAIL late_ready_idle: got %0b want 010", req_ready); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        do_reset();
        req_valid = 3'b110; req_write = '0; req_addr[1] = 12'h044; req_addr[2] = 12'h048;
        #1;
        tests++; if (req_ready !== 3'b010) begin fails++; $display("FAIL rmid_grant: got %0b want 010", req_ready); end
        tick(); tick(); tick();
        #1 rstn = 1'b0;
        #1;
        tests++; if ({psel, penable} !== 2'b00) begin fails++; $display("FAIL rmid_async_drop: got %0b want 00", {psel, penable}); end
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen = seen | (|rsp_valid);
        end
        req_valid = '1;
        rstn = 1'b1;
        #1;
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL rmid_no_rsp: got %0b want 0", seen); end
        tests++; if (req_ready !== 3'b001) begin fails++; $display("FAIL rmid_first_grant: got %0b want 001", req_ready); end
    endtask

    task automatic test_timeout();
        do_reset();
        req_valid[2] = 1'b1; req_write[2] = 1'b0; req_addr[2] = 12'h7F0;
`ifdef APB_TIMEOUT_EN
        run_xfer(1000, 32'hFFFF_FFFF, 1'b0, 1'b1, '0);
        tests++; if (obs_n !== TO) begin fails++; $display("FAIL timeout_cycles: got %0d want %0d", obs_n, TO); end
        tests++; if (obs_rsp !== 3'b100 || obs_err !== 1'b1 || obs_rdata !== 32'h0) begin fails++; $display("FAIL timeout_rsp: got %0b/%0b/%0h want 100/1/0", obs_rsp, obs_err, obs_rdata); end
`else
        run_xfer(20, 32'h0BAD_F00D, 1'b0, 1'b1, '0);
        tests++; if (obs_n !== 21) begin fails++; $display("FAIL long_wait_cycles: got %0d want 21", obs_n); end
        tests++; if (obs_rsp !== 3'b100 || obs_err !== 1'b0 || obs_rdata !== 32'h0BAD_F00D) begin fails++; $display("FAIL long_wait_rsp: got %0b/%0b/%0h want 100/0/badf00d", obs_rsp, obs_err, obs_rdata); end
`endif
        tick();
        req_valid[0] = 1'b1;
        #1;
        tests++; if (req_ready !== 3'b001 || psel !== 1'b0) begin fails++; $display("FAIL after_abort_idle: got %0b/%0b want 001/0", req_ready, psel); end
    endtask

    // Transfer-level model: pending requests per requester, round-robin from the last grant,
    // 1 SETUP cycle, ACCESS until pready (or the timeout limit), then one response cycle.
    task automatic test_random();
        logic [NR-1:0] pend, exp_rdy, exp_rsp;
        logic pw [NR];
        logic [AW-1:0] pa [NR];
        logic [31:0] pd [NR];
        logic cw, exp_err, exp_psel, busy, rsp_due, acc;
        logic [AW-1:0] ca;
        logic [31:0] cd, exp_rd;
        int last, cur, k, g;
        do_reset();
        pend = '0; busy = 1'b0; rsp_due = 1'b0; last = NR - 1; cur = 0; k = 0;
        cw = 1'b0; ca = '0; cd = '0; exp_rd = '0; exp_err = 1'b0;
        for (int r = 0; r < NR; r++) begin pw[r] = 1'b0; pa[r] = '0; pd[r] = '0; end
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int r = 0; r < NR; r++) if (!pend[r] && $urandom_range(0, 2) == 0) begin
                pend[r] = 1'b1; pw[r] = 1'($urandom); pa[r] = AW'($urandom); pd[r] = $urandom;
            end
            for (int r = 0; r < NR; r++) begin req_write[r] = pw[r]; req_addr[r] = pa[r]; req_wdata[r] = pd[r]; end
            req_valid = pend;
            pready = $urandom_range(0, 2) == 0; prdata = $urandom; pslverr = $urandom_range(0, 3) == 0;
            #1;
            acc = !busy && (|pend);
            g = acc ? rr_next(last, pend) : 0;
            exp_rdy = acc ? NR'(1) << g : '0;
            exp_rsp = rsp_due ? NR'(1) << cur : '0;
            exp_psel = busy && !rsp_due;
            tests++; if (req_ready !== exp_rdy) begin fails++; $display("FAIL rnd_ready@%0d: got %0b want %0b", cyc, req_ready, exp_rdy); end
            tests++; if (rsp_valid !== exp_rsp) begin fails++; $display("FAIL rnd_rsp_valid@%0d: got %0b want %0b", cyc, rsp_valid, exp_rsp); end
            if (rsp_due) begin
                tests++; if (rsp_rdata !== exp_rd || rsp_err !== exp_err) begin fails++; $display("FAIL rnd_rsp@%0d: got %0h/%0b want %0h/%0b", cyc, rsp_rdata, rsp_err, exp_rd, exp_err); end
            end
            tests++; if (psel !== exp_psel || penable !== (exp_psel && k >= 2)) begin fails++; $display("FAIL rnd_phase@%0d: got %0b%0b want %0b%0b", cyc, psel, penable, exp_psel, exp_psel && k >= 2); end
            if (exp_psel) begin
                tests++; if (paddr !== ca || pwrite !== cw || pwdata !== cd) begin fails++; $display("FAIL rnd_payload@%0d: got %0h/%0b/%0h want %0h/%0b/%0h", cyc, paddr, pwrite, pwdata, ca, cw, cd); end
            end
            if (rsp_due) begin
                busy = 1'b0; rsp_due = 1'b0;
            end else if (busy && k >= 2 && pready) begin
                rsp_due = 1'b1; exp_rd = cw ? 32'h0 : prdata; exp_err = pslverr;
`ifdef APB_TIMEOUT_EN
            end else if (busy && k >= 2 && k - 1 == TO) begin
                rsp_due = 1'b1; exp_rd = 32'h0; exp_err = 1'b1;
`endif
            end
            if (acc) begin
                busy = 1'b1; cur = g; last = g; k = 0;
                cw = pw[g]; ca = pa[g]; cd = pd[g]; pend[g] = 1'b0;
            end
            tick();
            if (busy) k++;
        end
    endtask

    initial begin
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        pready = 1'b0; prdata = '0; pslverr = 1'b0;
        test_reset();
        test_single_read();
        test_fairness();
        test_wait_err();
        test_late_request();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
